epp_read_port: RTL
==================

Name: epp_read_port

Overview:
- Host-read side of the EPP parallel-port interface.
- Snoops EPP address-write cycles to track the current register address, and answers EPP data-read cycles (ctrlWr=1, stbData=0) with the selected byte.
- Buffers 16-bit ADC samples in an internal FIFO; the host drains it byte-wise.
- Sits beside the existing EPP write/config path. Its wait output is OR'd with the write path's wait at top level to form EppWait.

Parameters:
- FIFO_AW, 9, FIFO address width; depth = 2^FIFO_AW samples (512).
- ADDR_STATUS, 8'h00, status register address.
- ADDR_CNT_LO, 8'h01, FIFO count bits [7:0].
- ADDR_CNT_HI, 8'h02, FIFO count bits [FIFO_AW:8], zero-extended.
- ADDR_DATA_LO, 8'h10, sample low byte; a read pops the sample.
- ADDR_DATA_HI, 8'h11, high byte latched by the last ADDR_DATA_LO read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stbAddr  in  1  EPP address strobe, active low, asynchronous to clk
- stbData  in  1  EPP data strobe, active low, asynchronous to clk
- ctrlWr  in  1  EPP direction; 0 = host write, 1 = host read
- busEppIn  in  8  EPP bus input
- busEppOut  out  8  read data to the bus
- busEppOe  out  1  bus output enable; 1 = drive busEppOut
- eppWaitRd  out  1  wait contribution of this block
- sampleValid  in  1  one-cycle push strobe, ADC domain already in clk
- sampleData  in  16  sample to push
- fifoEmpty  out  1  FIFO empty
- fifoFull  out  1  FIFO full

Behaviour:
- Reset values:
  - busEppOut = 8'h00, busEppOe = 0, eppWaitRd = 0.
  - Address register = 8'h00, FIFO empty (count 0), hiLatch = 8'h00.
  - Sticky flags cleared; fifoEmpty = 1, fifoFull = 0.
- Input synchronisation:
  - stbAddr, stbData and ctrlWr each pass through a 2-FF synchroniser; FSM uses only synchronised versions (sA, sD, sW).
  - busEppIn is sampled at the same clk as the FSM acts on the strobe edge.
- FSM states: IDLE, ADDR_SNOOP, RD_SETUP, RD_HOLD, RELEASE.
- IDLE:
  - sA=0 and sW=0 → latch busEppIn into the address register, go to ADDR_SNOOP. eppWaitRd stays 0; the write path owns that handshake.
  - sD=0 and sW=1 → go to RD_SETUP.
  - sD=0 and sW=0 (data write) → ignored, remain IDLE.
  - If both strobes are low, the address strobe has priority.
- ADDR_SNOOP: wait for sA=1, then go to IDLE.
- RD_SETUP, one cycle:
  - busEppOut is loaded from the register map and busEppOe = 1.
  - Next cycle goes to RD_HOLD, where eppWaitRd = 1.
  - Strobe low to eppWaitRd high is 4 clk: 2 sync + RD_SETUP + RD_HOLD entry.
- RD_HOLD: hold busEppOut, busEppOe = 1 and eppWaitRd = 1 until sD=1, then go to RELEASE.
- RELEASE, one cycle:
  - eppWaitRd = 0, busEppOe = 0.
  - Read side effects are applied here (pop, flag clear). An aborted read therefore has no side effect unless the strobe release was seen.
  - Next state is IDLE.
- Register map at RD_SETUP:
  - STATUS = {4'b0, underflow, overflow, full, empty}.
  - CNT_LO, CNT_HI as defined under Parameters.
  - DATA_LO: FIFO head [7:0], and head [15:8] is copied into hiLatch. If the FIFO is empty it returns 8'h00 and marks an underflow pending.
  - DATA_HI: returns hiLatch.
  - Any other address returns 8'hFF.
- Read side effects in RELEASE:
  - DATA_LO with FIFO non-empty → pop 1 entry.
  - DATA_LO with FIFO empty → set the underflow sticky flag.
  - STATUS → clear both sticky flags. A flag event in the same cycle wins; the flag stays set.
- FIFO:
  - Push on sampleValid when not full. If full, the sample is dropped and overflow sets.
  - Simultaneous push and pop: both occur and the count is unchanged.
  - When full, a push coinciding with a pop is accepted.
  - Pointers wrap modulo depth; count is FIFO_AW+1 bits wide.
- rst_n asserted mid-cycle: everything returns to reset values immediately (asynchronous), which releases the bus.

Optional Feature:
- Macro EPP_RD_SCRATCH_EN.
- Defined:
  - An 8-bit scratch register at address 8'h20, reset 8'h00.
  - Written on an EPP data write: in IDLE, sD=0 and sW=0 with address 8'h20 latch busEppIn, then wait for sD=1. eppWaitRd stays 0.
  - Reading 8'h20 returns the scratch value; used for host link test.
- Undefined: no scratch register; address 8'h20 reads 8'hFF and data writes are ignored entirely.

Test Plan:
- Reset then read STATUS → busEppOut = 8'h01 (empty only); eppWaitRd rises 4 clk after stbData falls; busEppOe/eppWaitRd drop 1 clk after the synchronised release.
- Push 16'hA55A and 16'h1234; address write 8'h10, read, then address write 8'h11, read → bytes 8'h5A then 8'hA5; CNT_LO reads 8'h01.
- Fill 512 samples plus 1 extra → fifoFull = 1 and STATUS = 8'h06. A following STATUS read clears overflow; the next STATUS read = 8'h02.
- Read DATA_LO on empty FIFO → 8'h00; STATUS then reads 8'h09; count stays 0.
- Pulse sampleValid in the RELEASE cycle of a DATA_LO pop with count 5 → count stays 5; data order is preserved across pointer wrap after 600 push/pop pairs.
- With EPP_RD_SCRATCH_EN: address write 8'h20, data write 8'h3C, read → 8'h3C. Without it the same read returns 8'hFF. Assert rst_n during RD_HOLD → busEppOe = 0 and eppWaitRd = 0 immediately.

Source files
------------

// File: rtl/epp_read_port_if.sv
// EPP bus signals seen by the host-read port: strobes, direction and the shared data byte.
// master = host/bus side, slave = epp_read_port.
interface epp_read_port_if;
    logic       stbAddr;
    logic       stbData;
    logic       ctrlWr;
    logic [7:0] busEppIn;
    logic [7:0] busEppOut;
    logic       busEppOe;
    logic       eppWaitRd;

    modport master (
        output stbAddr, stbData, ctrlWr, busEppIn,
        input  busEppOut, busEppOe, eppWaitRd
    );

    modport slave (
        input  stbAddr, stbData, ctrlWr, busEppIn,
        output busEppOut, busEppOe, eppWaitRd
    );
endinterface

// File: rtl/epp_read_port.sv
// EPP host-read port: snoops address cycles, answers data reads from a register map and a
// 16-bit sample FIFO. Optional scratch register at 8'h20 enabled by EPP_RD_SCRATCH_EN.
module epp_read_port #(
    parameter int unsigned FIFO_AW      = 9,
    parameter logic [7:0]  ADDR_STATUS  = 8'h00,
    parameter logic [7:0]  ADDR_CNT_LO  = 8'h01,
    parameter logic [7:0]  ADDR_CNT_HI  = 8'h02,
    parameter logic [7:0]  ADDR_DATA_LO = 8'h10,
    parameter logic [7:0]  ADDR_DATA_HI = 8'h11
) (
    input  logic            clk,
    input  logic            rst_n,
    epp_read_port_if.slave  epp,
    input  logic            sampleValid,
    input  logic [15:0]     sampleData,
    output logic            fifoEmpty,
    output logic            fifoFull
);

`ifdef EPP_RD_SCRATCH_EN
    localparam bit ScratchEn = 1'b1;
`else
    localparam bit ScratchEn = 1'b0;
`endif
    localparam logic [7:0]       AddrScratch = 8'h20;
    localparam int unsigned      Depth       = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FullCount   = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StAddrSnoop, StRdSetup, StRdHold, StRelease, StWrHold
    } state_e;

    state_e state_q;
    logic [1:0] sync_a_q, sync_d_q, sync_w_q;
    logic s_a, s_d, s_w;
    logic [7:0] addr_q, out_q, hi_latch_q, scratch_q, rd_data;
    logic oe_q, wait_q;
    logic rd_pop_q, rd_unf_q, rd_clr_q;
    logic ovf_q, unf_q;

    logic [15:0] mem [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0] count_q;
    logic [15:0] head;
    logic push, pop, ovf_evt, in_release, is_lo, is_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a_q <= 2'b11;
            sync_d_q <= 2'b11;
            sync_w_q <= 2'b00;
        end else begin
            sync_a_q <= {sync_a_q[0], epp.stbAddr};
            sync_d_q <= {sync_d_q[0], epp.stbData};
            sync_w_q <= {sync_w_q[0], epp.ctrlWr};
        end
    end

    assign s_a = sync_a_q[1];
    assign s_d = sync_d_q[1];
    assign s_w = sync_w_q[1];

    assign fifoEmpty  = (count_q == '0);
    assign fifoFull   = (count_q == FullCount);
    assign head       = mem[rd_ptr_q];
    assign in_release = (state_q == StRelease);
    assign pop        = in_release && rd_pop_q;
    // A pop in the same cycle frees a slot, so a push at full is still accepted then.
    assign push       = sampleValid && (!fifoFull || pop);
    assign ovf_evt    = sampleValid && fifoFull && !pop;
    assign is_lo      = (addr_q == ADDR_DATA_LO);
    assign is_status  = (addr_q == ADDR_STATUS);

    always_comb begin
        rd_data = 8'hFF;
        case (addr_q)
            ADDR_STATUS:  rd_data = {4'b0000, unf_q, ovf_q, fifoFull, fifoEmpty};
            ADDR_CNT_LO:  rd_data = count_q[7:0];
            ADDR_CNT_HI:  rd_data = 8'(count_q >> 8);
            ADDR_DATA_LO: rd_data = fifoEmpty ? 8'h00 : head[7:0];
            ADDR_DATA_HI: rd_data = hi_latch_q;
            default:      rd_data = 8'hFF;
        endcase
        if (ScratchEn && addr_q == AddrScratch) rd_data = scratch_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= 8'h00;
            out_q      <= 8'h00;
            oe_q       <= 1'b0;
            wait_q     <= 1'b0;
            hi_latch_q <= 8'h00;
            scratch_q  <= 8'h00;
            rd_pop_q   <= 1'b0;
            rd_unf_q   <= 1'b0;
            rd_clr_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!s_a && !s_w) begin
                        addr_q  <= epp.busEppIn;
                        state_q <= StAddrSnoop;
                    end else if (!s_d && s_w) begin
                        out_q    <= rd_data;
                        oe_q     <= 1'b1;
                        rd_pop_q <= is_lo && !fifoEmpty;
                        rd_unf_q <= is_lo && fifoEmpty;
                        rd_clr_q <= is_status;
                        if (is_lo && !fifoEmpty) hi_latch_q <= head[15:8];
                        state_q  <= StRdSetup;
                    end else if (ScratchEn && !s_d && !s_w && addr_q == AddrScratch) begin
                        scratch_q <= epp.busEppIn;
                        state_q   <= StWrHold;
                    end
                end
                StAddrSnoop: if (s_a) state_q <= StIdle;
                StRdSetup: begin
                    wait_q  <= 1'b1;
                    state_q <= StRdHold;
                end
                StRdHold: begin
                    if (s_d) begin
                        wait_q  <= 1'b0;
                        oe_q    <= 1'b0;
                        state_q <= StRelease;
                    end
                end
                StRelease: state_q <= StIdle;
                StWrHold:  if (s_d) state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    assign epp.busEppOut = out_q;
    assign epp.busEppOe  = oe_q;
    assign epp.eppWaitRd = wait_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            if (push && !pop)      count_q <= count_q + (FIFO_AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (FIFO_AW + 1)'(1);
            // A new event in the clearing cycle keeps its flag set.
            ovf_q <= ovf_evt || (ovf_q && !(in_release && rd_clr_q));
            unf_q <= (in_release && rd_unf_q) || (unf_q && !(in_release && rd_clr_q));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= sampleData;
    end

endmodule
